// File: rtl/hit_drain_fifo_pkg.sv
// Shared types and sizing for the hit drain FIFO.
//   hit_bundle_t : one rasteriser bundle (SAMPS lanes of x/y/z, shared colour, lane mask)
//   hit_t        : one serialised hit (position, colour, source lane)
//   lane_count   : number of valid lanes in a mask
package rast_hit_pkg;

    localparam int SIGFIG = 24;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int SAMPS  = 4;
    localparam int LANE_W = (SAMPS > 1) ? $clog2(SAMPS) : 1;

    typedef struct packed {
        logic [SAMPS-1:0][AXIS-1:0][SIGFIG-1:0] pos;
        logic [COLORS-1:0][SIGFIG-1:0]          color;
        logic [SAMPS-1:0]                       vmask;
    } hit_bundle_t;

    typedef struct packed {
        logic [AXIS-1:0][SIGFIG-1:0]   pos;
        logic [COLORS-1:0][SIGFIG-1:0] color;
        logic [LANE_W-1:0]             lane;
    } hit_t;

    function automatic int unsigned lane_count(input logic [SAMPS-1:0] mask);
        int unsigned n;
        n = 0;
        for (int i = 0; i < SAMPS; i++) begin
            if (mask[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/hit_drain_fifo_if.sv
// Bus bundle between the sample-test stage, the drain FIFO and the z-buffer
// write unit.
//   master : upstream/downstream environment (drives bundles and zb_ready_H)
//   slave  : the drain FIFO (drives halt, serialised hit and status)
interface hit_drain_fifo_if;
    import rast_hit_pkg::*;

    logic signed [SIGFIG-1:0] hit_R18S   [AXIS][SAMPS];
    logic        [SIGFIG-1:0] color_R18U [COLORS];
    logic        [SAMPS-1:0]  hit_valid_R18H;
    logic                     halt_RnnnnL;

    logic                     zb_valid_H;
    logic                     zb_ready_H;
    logic signed [SIGFIG-1:0] zb_hit_S   [AXIS];
    logic        [SIGFIG-1:0] zb_color_U [COLORS];
    logic        [LANE_W-1:0] zb_lane_U;

    logic                     overflow_err_H;
    logic        [31:0]       samples_out_U;

    modport master (
        output hit_R18S, color_R18U, hit_valid_R18H, zb_ready_H,
        input  halt_RnnnnL, zb_valid_H, zb_hit_S, zb_color_U, zb_lane_U,
               overflow_err_H, samples_out_U
    );

    modport slave (
        input  hit_R18S, color_R18U, hit_valid_R18H, zb_ready_H,
        output halt_RnnnnL, zb_valid_H, zb_hit_S, zb_color_U, zb_lane_U,
               overflow_err_H, samples_out_U
    );

endinterface

// File: rtl/hit_drain_fifo_lane_pick.sv
// Lowest-index priority encoder over a lane mask.
//   mask_i : lane mask
//   idx_o  : index of the lowest set bit (0 when mask is empty)
//   any_o  : at least one bit set
//   last_o : exactly one bit set, i.e. the picked lane is the final one
module lane_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o,
    output logic          last_o
);

    always_comb begin
        idx_o = '0;
        // Scan high to low so the lowest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) idx_o = IW'(i);
        end
        any_o  = |mask_i;
        last_o = any_o && ((mask_i & (mask_i - N'(1))) == '0);
    end

endmodule

// File: rtl/hit_drain_fifo.sv
// Hit drain FIFO: buffers hit bundles from the sample-test stage and
// serialises them, one hit per cycle, onto the z-buffer valid/ready port.
//   clk  : clock
//   rst  : asynchronous reset, active low
//   bus  : slave side of hit_drain_fifo_if
//          in : hit_R18S, color_R18U, hit_valid_R18H, zb_ready_H
//          out: halt_RnnnnL, zb_valid_H, zb_hit_S, zb_color_U, zb_lane_U,
//               overflow_err_H, samples_out_U
module hit_drain_fifo
    import rast_hit_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SKID  = 5
) (
    input  logic           clk,
    input  logic           rst,
    hit_drain_fifo_if.slave bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] HALT_CNT = CW'(DEPTH - SKID);

    hit_bundle_t       mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [SAMPS-1:0]  work_mask_q, work_mask_d;
    logic              halt_q;
    logic              overflow_q;
    logic [31:0]       samples_q;

    hit_bundle_t       in_bundle;
    hit_bundle_t       head;
    hit_t              out_hit;
    logic              push_req, push, pop, xfer, full, empty;
    logic [SAMPS-1:0]  lane_bit;
    logic [LANE_W-1:0] pick_idx;
    logic              pick_any, pick_last;

    lane_pick #(.N(SAMPS), .IW(LANE_W)) u_lane_pick (
        .mask_i (work_mask_q),
        .idx_o  (pick_idx),
        .any_o  (pick_any),
        .last_o (pick_last)
    );

    always_comb begin
        in_bundle = '0;
        for (int s = 0; s < SAMPS; s++) begin
            for (int a = 0; a < AXIS; a++) begin
                in_bundle.pos[s][a] = bus.hit_R18S[a][s];
            end
        end
        for (int c = 0; c < COLORS; c++) begin
            in_bundle.color[c] = bus.color_R18U[c];
        end
        in_bundle.vmask = bus.hit_valid_R18H;
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        push_req = |bus.hit_valid_R18H;
        xfer     = !empty && bus.zb_ready_H && pick_any;
        pop      = xfer && pick_last;
        // At full a push is only accepted when the head leaves this cycle.
        push     = push_req && (!full || pop);
        lane_bit = SAMPS'(1) << pick_idx;

        count_d  = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        work_mask_d = work_mask_q;
        if (xfer) work_mask_d = work_mask_q & ~lane_bit;
        if (pop) begin
            // Next head is either already stored, or is the bundle arriving now.
            if (count_q > CW'(1)) work_mask_d = mem_q[rd_ptr_q + PW'(1)].vmask;
            else if (push)        work_mask_d = in_bundle.vmask;
            else                  work_mask_d = '0;
        end else if (empty && push) begin
            work_mask_d = in_bundle.vmask;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_bundle;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            work_mask_q <= '0;
            halt_q      <= 1'b1;
            overflow_q  <= 1'b0;
            samples_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            work_mask_q <= work_mask_d;
            // Stall early enough that SKID bundles still in flight all fit.
            halt_q      <= (count_d < HALT_CNT);
            if (push_req && full && !pop) overflow_q <= 1'b1;
            if (xfer) samples_q <= samples_q + 32'd1;
        end
    end

    always_comb begin
        out_hit = '0;
        if (!empty) begin
            out_hit.pos   = head.pos[pick_idx];
            out_hit.color = head.color;
            out_hit.lane  = pick_idx;
        end
    end

    always_comb begin
        for (int a = 0; a < AXIS; a++) begin
            bus.zb_hit_S[a] = $signed(out_hit.pos[a]);
        end
        for (int c = 0; c < COLORS; c++) begin
            bus.zb_color_U[c] = out_hit.color[c];
        end
    end

    assign bus.zb_valid_H     = !empty;
    assign bus.zb_lane_U      = out_hit.lane;
    assign bus.halt_RnnnnL    = halt_q;
    assign bus.overflow_err_H = overflow_q;
    assign bus.samples_out_U  = samples_q;

endmodule

// File: tb/tb_hit_drain_fifo.sv
module tb_hit_drain_fifo;
    import rast_hit_pkg::*;

    localparam int DEPTH = 8;
    localparam int SKID  = 5;

    typedef struct packed {
        logic [LANE_W-1:0]             lane;
        logic [AXIS-1:0][SIGFIG-1:0]   pos;
        logic [COLORS-1:0][SIGFIG-1:0] col;
    } exp_hit_t;

    logic clk = 1'b0;
    logic rst;

    hit_drain_fifo_if bus();

    hit_drain_fifo #(.DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of bundles (lanes still owed) plus the
    // expected serial hit stream.
    exp_hit_t    exp_q[$];
    int          bq_left[$];
    logic [31:0] m_samples;
    logic        m_ovf;
    logic        m_halt;
    int          skid_cnt;

    exp_hit_t mon_e, mon_cur, mon_saved;
    bit       mon_held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        bq_left.delete();
        m_samples = '0;
        m_ovf     = 1'b0;
        m_halt    = 1'b1;
        skid_cnt  = 0;
    endtask

    task automatic check_status();
        chk("zb_valid", 64'(bus.zb_valid_H), 64'(bq_left.size() != 0));
        chk("halt", 64'(bus.halt_RnnnnL), 64'(m_halt));
        chk("overflow", 64'(bus.overflow_err_H), 64'(m_ovf));
        chk("samples_out", 64'(bus.samples_out_U), 64'(m_samples));
    endtask

    // Called #1 after a rising edge: checks state left by that edge, drives
    // the inputs for the next edge and advances the model across it.
    task automatic step(input logic [SAMPS-1:0] m, input logic rdy);
        logic [COLORS-1:0][SIGFIG-1:0]          col;
        logic [SAMPS-1:0][AXIS-1:0][SIGFIG-1:0] pos;
        exp_hit_t h;
        bit       pop_m;
        check_status();
        for (int c = 0; c < COLORS; c++) col[c] = SIGFIG'($urandom);
        for (int s = 0; s < SAMPS; s++)
            for (int a = 0; a < AXIS; a++) pos[s][a] = SIGFIG'($urandom);
        bus.hit_valid_R18H = m;
        bus.zb_ready_H     = rdy;
        for (int a = 0; a < AXIS; a++)
            for (int s = 0; s < SAMPS; s++) bus.hit_R18S[a][s] = $signed(pos[s][a]);
        for (int c = 0; c < COLORS; c++) bus.color_R18U[c] = col[c];

        pop_m = 1'b0;
        if (bq_left.size() != 0 && rdy) begin
            m_samples  = m_samples + 32'd1;
            bq_left[0] = bq_left[0] - 1;
            if (bq_left[0] == 0) pop_m = 1'b1;
        end
        if (m != '0) begin
            if (bq_left.size() < DEPTH || pop_m) begin
                bq_left.push_back($countones(m));
                for (int s = 0; s < SAMPS; s++) begin
                    if (m[s]) begin
                        h.lane = LANE_W'(s);
                        h.pos  = pos[s];
                        h.col  = col;
                        exp_q.push_back(h);
                    end
                end
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (pop_m) void'(bq_left.pop_front());
        m_halt = (bq_left.size() < DEPTH - SKID);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        bus.hit_valid_R18H = '0;
        bus.zb_ready_H     = 1'b1;
        model_reset();
        #1;
        chk("rst_valid", 64'(bus.zb_valid_H), 64'(0));
        chk("rst_halt", 64'(bus.halt_RnnnnL), 64'(1));
        chk("rst_overflow", 64'(bus.overflow_err_H), 64'(0));
        chk("rst_samples", 64'(bus.samples_out_U), 64'(0));
        chk("rst_lane", 64'(bus.zb_lane_U), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Scoreboard monitor: samples mid-cycle, pops on every output transfer.
    initial begin : monitor
        mon_held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_held = 1'b0;
            end else begin
                mon_cur.lane = bus.zb_lane_U;
                for (int a = 0; a < AXIS; a++) mon_cur.pos[a] = bus.zb_hit_S[a];
                for (int c = 0; c < COLORS; c++) mon_cur.col[c] = bus.zb_color_U[c];
                if (mon_held) begin
                    chk("hold_valid", 64'(bus.zb_valid_H), 64'(1));
                    checks++;
                    if (mon_cur !== mon_saved) begin
                        errors++;
                        $display("FAIL hold_data: got %0h, expected %0h", mon_cur, mon_saved);
                    end
                end
                if (bus.zb_valid_H && bus.zb_ready_H) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_hit: got lane %0d, expected no hit", mon_cur.lane);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("hit_lane", 64'(mon_cur.lane), 64'(mon_e.lane));
                        for (int a = 0; a < AXIS; a++)
                            chk("hit_pos", 64'(mon_cur.pos[a]), 64'(mon_e.pos[a]));
                        for (int c = 0; c < COLORS; c++)
                            chk("hit_color", 64'(mon_cur.col[c]), 64'(mon_e.col[c]));
                    end
                end
                mon_held = bus.zb_valid_H && !bus.zb_ready_H;
                mon_saved = mon_cur;
            end
        end
    end

    initial begin : driver
        logic [SAMPS-1:0] m;
        logic             rdy;
        rst = 1'b0;
        bus.hit_valid_R18H = '0;
        bus.zb_ready_H     = 1'b0;
        for (int a = 0; a < AXIS; a++)
            for (int s = 0; s < SAMPS; s++) bus.hit_R18S[a][s] = '0;
        for (int c = 0; c < COLORS; c++) bus.color_R18U[c] = '0;
        model_reset();
        #12 rst = 1'b1;
        @(posedge clk);
        #1;

        // Lanes 0 and 2, ready held high.
        step(4'b0101, 1'b1);
        repeat (3) step('0, 1'b1);

        // All lanes, ready toggling.
        step(4'b1111, 1'b0);
        for (int i = 0; i < 8; i++) step('0, (i % 2) == 0);
        step('0, 1'b1);

        // Empty mask bundles are ignored.
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Fill to DEPTH with ready low, then push+pop at full, then overflow.
        for (int i = 0; i < DEPTH; i++) step(SAMPS'(1) << $urandom_range(0, SAMPS - 1), 1'b0);
        step(SAMPS'(1) << $urandom_range(0, SAMPS - 1), 1'b1);
        step(SAMPS'(1) << $urandom_range(0, SAMPS - 1), 1'b0);
        step('0, 1'b0);
        repeat (4) step('0, 1'b1);

        // Reset mid-drain with four bundles queued.
        check_status();
        pulse_reset();
        step(4'b1010, 1'b1);
        repeat (3) step('0, 1'b1);

        // Random traffic; upstream honours halt with SKID cycles of slack.
        for (int i = 0; i < 400; i++) begin
            m   = ($urandom_range(0, 3) == 0) ? '0 : SAMPS'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            if (!m_halt) begin
                if (skid_cnt < SKID) skid_cnt++;
                else m = '0;
            end else begin
                skid_cnt = 0;
            end
            step(m, rdy);
        end

        // Drain, bounded.
        for (int i = 0; i < 100 && bq_left.size() != 0; i++) step('0, 1'b1);
        if (bq_left.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d bundles left, expected 0", bq_left.size());
        end
        step('0, 1'b1);
        check_status();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
